de_scoreboard_ctrl: RTL
=======================

Name: de_scoreboard_ctrl

Overview:
- Per-register scoreboard and issue controller for the decode stage.
- Tracks the in-flight writers of each architectural register between DE issue and WB retire, and produces the DE stall to FE.
- Serializes CSR instructions by draining the pipeline before they issue.
- Replaces address-compare hazard detection: stall depends only on scoreboard state plus same-cycle WB release.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is never tracked.
- REGNOBITS, 5, register ID width.
- CNTBITS, 2, width of each pending-writer counter; CNT_MAX = 2^CNTBITS-1.
- INFLBITS, 4, width of the total in-flight counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- de_valid  in  1  DE holds a valid (nonzero) instruction this cycle.
- de_rs1_read  in  1  instruction reads rs1.
- de_rs1  in  REGNOBITS  rs1 ID.
- de_rs2_read  in  1  instruction reads rs2.
- de_rs2  in  REGNOBITS  rs2 ID.
- de_wr_reg  in  1  instruction writes rd.
- de_rd  in  REGNOBITS  rd ID.
- de_serialize  in  1  instruction is CSRR/CSRW and must issue to an empty pipeline.
- br_flush  in  1  AGEX branch redirect; the DE instruction is squashed.
- wr_reg_WB  in  1  WB retires a register write this cycle.
- wregno_WB  in  REGNOBITS  WB destination register.
- stall_DE  out  1  combinational stall to FE and the DE latch.
- issue_DE  out  1  combinational: the DE instruction enters the DE latch at the next posedge.
- inflight  out  INFLBITS  registered total of tracked pending writes.
- drain_busy  out  1  registered: FSM is in DRAIN.
- sb_err  out  1  sticky underflow/overflow error.

Behaviour:
- Reset (async, posedge reset):
  - All counters 0, inflight=0, FSM=RUN, sb_err=0.
  - Combinational outputs follow: stall_DE=0, issue_DE=0 when de_valid=0.
- Registers: cnt[r] (CNTBITS) for r=1..NREGS-1. cnt[0] is constant 0.
- Release term: rel(r) = wr_reg_WB & (wregno_WB==r) & (r!=0). The WB regfile write lands on negedge, so a released register is readable in the same cycle.
- Busy term: busy(r) = (cnt[r] > rel(r)), i.e. cnt[r]>=2, or cnt[r]==1 with no release this cycle.
- Data hazard: haz = (de_rs1_read & busy(de_rs1)) | (de_rs2_read & busy(de_rs2)).
- Structural hazard: full = de_wr_reg & de_rd!=0 & cnt[de_rd]==CNT_MAX & !rel(de_rd).
- Serialization hazard:
  - ser_haz = de_serialize & (inflight - (wr_reg_WB & wregno_WB!=0)) != 0.
  - ser_haz is also asserted whenever FSM is in DRAIN.
- Stall: stall_DE = de_valid & !br_flush & (haz | full | ser_haz).
- Issue: issue_DE = de_valid & !br_flush & !stall_DE.
- Counter update at posedge, per register r:
  - inc = issue_DE & de_wr_reg & de_rd==r & r!=0; dec = rel(r).
  - inc&dec: unchanged.
  - inc only: +1.
  - dec only: -1 if cnt>0; if cnt==0, hold at 0 and set sb_err.
  - Increment at CNT_MAX cannot occur (blocked by full); if forced, hold and set sb_err.
- inflight is updated by the same inc/dec totals (net -1, 0 or +1) and saturates at 0 and at 2^INFLBITS-1.
- FSM RUN / DRAIN:
  - RUN -> DRAIN when de_valid & de_serialize & !br_flush & ser_haz.
  - DRAIN -> RUN when the next-state inflight is 0, or when br_flush is asserted.
  - The CSR instruction issues in the first cycle after returning to RUN if it is still in DE; its non-CSR writes then count normally.
  - drain_busy = (state==DRAIN).
- br_flush dominates: no issue, no stall, no increment, no FSM entry. WB releases still apply.
- Reset asserted mid-operation clears all state immediately. No in-flight write is remembered across reset; the pipeline latches clear at the same time.
- Latency:
  - stall and issue are 0-cycle combinational.
  - Scoreboard state is visible at the posedge following issue.
  - A dependent instruction issues in the cycle its producer is in WB, not later.

Test Plan:
- Reset, then issue ADDI x5 with de_wr_reg=1, rd=5 -> at next posedge cnt[5]=1, inflight=1; a following ADD with rs1=5 gives stall_DE=1 until wr_reg_WB=1, wregno_WB=5, then stall_DE=0 and issue_DE=1 in that same cycle.
- Write to x0: issue with rd=0, then read rs1=0 -> cnt unchanged, inflight=0, stall_DE never asserts.
- Three back-to-back writes to x7 (cnt[7]=3) and a fourth write to x7 -> stall_DE=1 (full); with same-cycle WB release of x7 -> issue_DE=1 and cnt[7] stays 3.
- CSRW arrives with inflight=2 -> drain_busy=1, stall_DE=1 for exactly 2 WB retirements, then drain_busy=0 and issue_DE=1.
- br_flush=1 on a cycle with a hazarded instruction in DE -> stall_DE=0, issue_DE=0, no counter change; in DRAIN, the FSM returns to RUN.
- WB release of x9 with cnt[9]=0 -> sb_err=1 and sticky; assert reset mid-run with inflight=3 -> all outputs 0 immediately.

Source files
------------

// File: rtl/de_scoreboard_ctrl_if.sv
// Decode-stage scoreboard bundle: DE instruction fields, AGEX flush, WB retire
// and the scoreboard's stall/issue/status outputs.
interface de_scoreboard_ctrl_if #(
   parameter int REGNOBITS = 5,
   parameter int INFLBITS  = 4
);
   logic                 de_valid;
   logic                 de_rs1_read;
   logic [REGNOBITS-1:0] de_rs1;
   logic                 de_rs2_read;
   logic [REGNOBITS-1:0] de_rs2;
   logic                 de_wr_reg;
   logic [REGNOBITS-1:0] de_rd;
   logic                 de_serialize;
   logic                 br_flush;
   logic                 wr_reg_WB;
   logic [REGNOBITS-1:0] wregno_WB;
   logic                 stall_DE;
   logic                 issue_DE;
   logic [INFLBITS-1:0]  inflight;
   logic                 drain_busy;
   logic                 sb_err;

   // Pipeline side: presents DE/AGEX/WB information, consumes stall/issue.
   modport master (
      output de_valid, de_rs1_read, de_rs1, de_rs2_read, de_rs2,
             de_wr_reg, de_rd, de_serialize, br_flush, wr_reg_WB, wregno_WB,
      input  stall_DE, issue_DE, inflight, drain_busy, sb_err
   );

   // Scoreboard side.
   modport slave (
      input  de_valid, de_rs1_read, de_rs1, de_rs2_read, de_rs2,
             de_wr_reg, de_rd, de_serialize, br_flush, wr_reg_WB, wregno_WB,
      output stall_DE, issue_DE, inflight, drain_busy, sb_err
   );
endinterface

// File: rtl/de_scoreboard_ctrl.sv
// Per-register pending-writer scoreboard and DE issue control.
// A register is busy while it has outstanding writers, except that the last
// writer retiring in WB this cycle frees it (the regfile writes on negedge).
// CSR instructions wait in DE until no tracked write is in flight.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal issue; hazards decided by scoreboard + WB release
// S_DRAIN | CSR waiting in DE; stall until in-flight writes reach zero
module de_scoreboard_ctrl #(
   parameter int NREGS     = 32,
   parameter int REGNOBITS = 5,
   parameter int CNTBITS   = 2,
   parameter int INFLBITS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   de_scoreboard_ctrl_if.slave  sb
);

   typedef enum logic {S_RUN, S_DRAIN} state_t;

   localparam logic [CNTBITS-1:0]  CNT_MAX  = '1;
   localparam logic [CNTBITS-1:0]  CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};
   localparam logic [INFLBITS-1:0] INFL_MAX = '1;
   localparam logic [INFLBITS-1:0] INFL_ONE = {{(INFLBITS-1){1'b0}}, 1'b1};

   state_t               state_q, state_nxt;
   logic [CNTBITS-1:0]   cnt_q   [NREGS];
   logic [CNTBITS-1:0]   cnt_nxt [NREGS];
   logic [INFLBITS-1:0]  inflight_q, infl_nxt, infl_after_wb;
   logic                 err_q, err_set;

   logic                 rel_any, rel_rs1, rel_rs2, rel_rd;
   logic                 busy_rs1, busy_rs2;
   logic                 haz, full, ser_haz;
   logic                 stall, issue, inc_any;
   logic [NREGS-1:0]     inc_vec, dec_vec;

   // Hazard evaluation and combinational stall/issue.
   always_comb begin
      rel_any  = sb.wr_reg_WB & (sb.wregno_WB != '0);
      rel_rs1  = rel_any & (sb.wregno_WB == sb.de_rs1);
      rel_rs2  = rel_any & (sb.wregno_WB == sb.de_rs2);
      rel_rd   = rel_any & (sb.wregno_WB == sb.de_rd);
      // cnt_q[0] is held at zero, so x0 is never busy or full.
      busy_rs1 = cnt_q[sb.de_rs1] > {{(CNTBITS-1){1'b0}}, rel_rs1};
      busy_rs2 = cnt_q[sb.de_rs2] > {{(CNTBITS-1){1'b0}}, rel_rs2};
      haz      = (sb.de_rs1_read & busy_rs1) | (sb.de_rs2_read & busy_rs2);
      full     = sb.de_wr_reg & (sb.de_rd != '0) &
                 (cnt_q[sb.de_rd] == CNT_MAX) & ~rel_rd;
      infl_after_wb = inflight_q - {{(INFLBITS-1){1'b0}}, rel_any};
      ser_haz  = (sb.de_serialize & (infl_after_wb != '0)) | (state_q == S_DRAIN);
      stall    = sb.de_valid & ~sb.br_flush & (haz | full | ser_haz);
      issue    = sb.de_valid & ~sb.br_flush & ~stall;
      inc_any  = issue & sb.de_wr_reg & (sb.de_rd != '0);
   end

   // Per-register increment/decrement strobes and next counter values.
   always_comb begin
      err_set = 1'b0;
      inc_vec = '0;
      dec_vec = '0;
      for (int r = 0; r < NREGS; r++) begin
         cnt_nxt[r] = cnt_q[r];
         if (r != 0) begin
            inc_vec[r] = inc_any & (sb.de_rd == REGNOBITS'(r));
            dec_vec[r] = rel_any & (sb.wregno_WB == REGNOBITS'(r));
            if (inc_vec[r] & ~dec_vec[r]) begin
               if (cnt_q[r] == CNT_MAX) err_set = 1'b1;
               else                     cnt_nxt[r] = cnt_q[r] + CNT_ONE;
            end else if (dec_vec[r] & ~inc_vec[r]) begin
               if (cnt_q[r] == '0) err_set = 1'b1;
               else                cnt_nxt[r] = cnt_q[r] - CNT_ONE;
            end
         end
      end
   end

   // Total in-flight count: net of this cycle's issue and retire, saturating.
   always_comb begin
      infl_nxt = inflight_q;
      if (inc_any & ~rel_any) begin
         if (inflight_q != INFL_MAX) infl_nxt = inflight_q + INFL_ONE;
      end else if (rel_any & ~inc_any) begin
         if (inflight_q != '0) infl_nxt = inflight_q - INFL_ONE;
      end
   end

   // RUN/DRAIN next-state; a flush abandons the drain since the CSR is gone.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_RUN:   if (sb.de_valid & sb.de_serialize & ~sb.br_flush & ser_haz)
                     state_nxt = S_DRAIN;
         S_DRAIN: if ((infl_nxt == '0) | sb.br_flush)
                     state_nxt = S_RUN;
         default: state_nxt = S_RUN;
      endcase
   end

   // State register for FSM, counters, in-flight total and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_RUN;
         inflight_q <= '0;
         err_q      <= 1'b0;
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      end else begin
         state_q    <= state_nxt;
         inflight_q <= infl_nxt;
         err_q      <= err_q | err_set;
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_nxt[r];
      end
   end

   // Output drive.
   always_comb begin
      sb.stall_DE   = stall;
      sb.issue_DE   = issue;
      sb.inflight   = inflight_q;
      sb.drain_busy = (state_q == S_DRAIN);
      sb.sb_err     = err_q;
   end

endmodule
